pipe_scheduler: RTL

- Run-time sequencer for the pipe-obstacle height table.
- Steps the table rotation index 0..4 as pipes scroll off screen.
- Raises the difficulty class (gap shrink of 12 px per class) every N pipes passed.
- Supplies the common horizontal scroll offset and score to the obstacle/VGA drawing logic.
- Sits between the game-control FSM (start/crash) and the height table plus obstacle renderer.

---
 rtl/pipe_scheduler_if.sv | 28 ++
 rtl/pipe_scheduler.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_scheduler_if.sv
// Purpose : handshake/bus bundle between game control, pipe_scheduler and the height table / renderer.
// Latency : none; this file only carries wires.
// Flow    : level/pulse signalling only. There is no backpressure path.
// Ports   : start/crash/frame_tick come from game control and the video timing.
//           rom_idx/cla/x_offset/score/running/dead go to the height table and the renderer.
interface pipe_scheduler_if;
    logic       start;
    logic       crash;
    logic       frame_tick;
    logic [2:0] rom_idx;
    logic [3:0] cla;
    logic [9:0] x_offset;
    logic [7:0] score;
    logic       running;
    logic       dead;

    // Game-control side: drives the requests and observes the scheduler state.
    modport master (
        output start, crash, frame_tick,
        input  rom_idx, cla, x_offset, score, running, dead
    );

    // Scheduler side.
    modport slave (
        input  start, crash, frame_tick,
        output rom_idx, cla, x_offset, score, running, dead
    );
endinterface

// File: rtl/pipe_scheduler.sv
// Purpose : sequences the pipe-obstacle height table (rotation index, difficulty class, scroll phase, score).
// Latency : every output is registered. Counter updates appear one clk after the frame_tick edge.
// Flow    : no backpressure. A frame_tick that arrives outside RUN, or together with crash, is dropped.
// Ports   : clk, rst (async active-high), and bus (slave modport).
//           bus inputs : start (level), crash (level), frame_tick (pulse).
//           bus outputs: rom_idx 0..4, cla 0..MAX_CLA, x_offset, score, running, dead.
module pipe_scheduler #(
    parameter int SPACING         = 128,
    parameter int SPEED           = 2,
    parameter int PIPES_PER_LEVEL = 4,
    parameter int MAX_CLA         = 10
) (
    input  logic             clk,
    input  logic             rst,
    pipe_scheduler_if.slave  bus
);

    localparam int LVL_W = (PIPES_PER_LEVEL > 1) ? $clog2(PIPES_PER_LEVEL) : 1;

    localparam logic [10:0]      SPACING_W = 11'(SPACING);
    localparam logic [10:0]      SPEED_W   = 11'(SPEED);
    localparam logic [9:0]       X_START   = 10'(SPACING - 1);
    localparam logic [3:0]       CLA_MAX   = 4'(MAX_CLA);
    localparam logic [LVL_W-1:0] LVL_LAST  = LVL_W'(PIPES_PER_LEVEL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LVL_W-1:0] lvl_cnt;
    logic [10:0]      x_ext;
    logic             clear;
    logic             advance;

    // The scroll arithmetic is done in 11 bits, so the wrap sum cannot overflow before truncation.
    assign x_ext   = {1'b0, bus.x_offset};

    // IDLE holds every counter at its reset value. Leaving DEAD wipes the frozen screen.
    assign clear   = (state == IDLE) || ((state == DEAD) && bus.start);

    // crash wins over a same-cycle tick, so that tick never moves a counter.
    assign advance = (state == RUN) && bus.frame_tick && !bus.crash;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (bus.crash) state_nxt = DEAD;
            DEAD:    if (bus.start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The status flags are registered from the next state, so they track the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.running <= 1'b0;
            bus.dead    <= 1'b0;
        end else begin
            bus.running <= (state_nxt == RUN);
            bus.dead    <= (state_nxt == DEAD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rom_idx  <= 3'd0;
            bus.cla      <= 4'd0;
            bus.x_offset <= X_START;
            bus.score    <= 8'd0;
            lvl_cnt      <= '0;
        end else if (clear) begin
            bus.rom_idx  <= 3'd0;
            bus.cla      <= 4'd0;
            bus.x_offset <= X_START;
            bus.score    <= 8'd0;
            lvl_cnt      <= '0;
        end else if (advance) begin
            if (x_ext >= SPEED_W) begin
                bus.x_offset <= 10'(x_ext - SPEED_W);
            end else begin
                // A pipe has scrolled off. Re-enter the next pitch with the leftover phase.
                bus.x_offset <= 10'(x_ext + SPACING_W - SPEED_W);
                bus.rom_idx  <= (bus.rom_idx == 3'd4) ? 3'd0 : bus.rom_idx + 3'd1;
                if (bus.score != 8'hFF) begin
                    bus.score <= bus.score + 8'd1;
                end
                if (lvl_cnt == LVL_LAST) begin
                    lvl_cnt <= '0;
                    if (bus.cla < CLA_MAX) begin
                        bus.cla <= bus.cla + 4'd1;
                    end
                end else begin
                    lvl_cnt <= lvl_cnt + LVL_W'(1);
                end
            end
        end
    end

endmodule
